// File: rtl/pre_des_deser_if.sv
// Bit-stream / DES / last-block bundle for pre_des_deser.
// The master drives the serial stream and acks; the slave is the deserializer.
interface pre_des_deser_if #(
  parameter int WORD_W = 64,
  parameter int CNT_W  = $clog2(WORD_W)
);
  logic              bit_in;
  logic              bit_en;
  logic              bit_last;
  logic              des_busy;
  logic [WORD_W-1:0] des_out;
  logic              des_wr;
  logic [WORD_W-1:0] last_out;
  logic [CNT_W-1:0]  last_size;
  logic              last_filled;
  logic              last_ack;
  logic              overflow;

  modport master (
    output bit_in, bit_en, bit_last, des_busy, last_ack,
    input  des_out, des_wr, last_out, last_size, last_filled, overflow
  );

  modport slave (
    input  bit_in, bit_en, bit_last, des_busy, last_ack,
    output des_out, des_wr, last_out, last_size, last_filled, overflow
  );
endinterface

// File: rtl/pre_des_deser.sv
// Serial-to-parallel front end for the DES core: MSB-first words to DES, partial tail via last block.
// Define PRE_DES_LSB_FIRST_EN for LSB-first shifting with a right-aligned partial last block.
module pre_des_deser #(
  parameter int WORD_W = 64,
  parameter int CNT_W  = $clog2(WORD_W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  pre_des_deser_if.slave  bus
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};

  logic [WORD_W-1:0] sreg_r, sreg_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [WORD_W-1:0] hold_r, hold_n;
  logic              hold_valid_r, hold_valid_n;
  logic              des_wr_r, des_wr_n;
  logic [WORD_W-1:0] des_out_r, des_out_n;
  logic [WORD_W-1:0] last_out_r, last_out_n;
  logic [CNT_W-1:0]  last_size_r, last_size_n;
  logic              last_pending_r, last_pending_n;
  logic              last_filled_r, last_filled_n;
  logic              overflow_r, overflow_n;

  logic              accept_s;
  logic              word_done_s;
  logic              issue_s;
  logic [WORD_W-1:0] full_word_s;
  logic [WORD_W-1:0] partial_s;

  // Datapath decode: incoming word with this bit, and the aligned partial tail.
  always_comb begin
    accept_s    = bus.bit_en & ~last_pending_r;
    word_done_s = accept_s & (cnt_r == CNT_MAX);
    issue_s     = hold_valid_r & ~bus.des_busy & ~des_wr_r;
`ifdef PRE_DES_LSB_FIRST_EN
    full_word_s = {bus.bit_in, sreg_r[WORD_W-1:1]};
    // Received bits sit at the top; shifting down by ~cnt drops stale bits below them.
    partial_s   = full_word_s >> (~cnt_r);
`else
    full_word_s = {sreg_r[WORD_W-2:0], bus.bit_in};
    // Shifting up by ~cnt pushes stale bits from older words out of the top.
    partial_s   = full_word_s << (~cnt_r);
`endif
  end

  // Next-state logic for shifting, word hand-off, last-block and error tracking.
  always_comb begin
    sreg_n         = sreg_r;
    cnt_n          = cnt_r;
    hold_n         = hold_r;
    hold_valid_n   = hold_valid_r & ~issue_s;
    des_wr_n       = issue_s;
    des_out_n      = des_out_r;
    last_out_n     = last_out_r;
    last_size_n    = last_size_r;
    last_pending_n = last_pending_r;
    last_filled_n  = last_filled_r;
    overflow_n     = overflow_r;

    if (issue_s) begin
      des_out_n = hold_r;
    end else begin
      des_out_n = des_out_r;
    end

    if (accept_s) begin
      sreg_n = full_word_s;
      if (word_done_s) begin
        cnt_n = CNT_ZERO;
        // The hold slot is free if empty or being emptied by this cycle's write.
        if (~hold_valid_r | issue_s) begin
          hold_n       = full_word_s;
          hold_valid_n = 1'b1;
        end else begin
          overflow_n = 1'b1;
        end
        if (bus.bit_last) begin
          last_pending_n = 1'b1;
          last_size_n    = CNT_ZERO;
          last_out_n     = WORD_ZERO;
        end else begin
          last_pending_n = last_pending_r;
        end
      end else if (bus.bit_last) begin
        last_out_n     = partial_s;
        last_size_n    = cnt_r + CNT_ONE;
        cnt_n          = CNT_ZERO;
        last_pending_n = 1'b1;
      end else begin
        cnt_n = cnt_r + CNT_ONE;
      end
    end else if (bus.bit_en) begin
      overflow_n = 1'b1;
    end else begin
      overflow_n = overflow_r;
    end

    if (bus.last_ack & last_filled_r) begin
      last_pending_n = 1'b0;
      last_filled_n  = 1'b0;
    end else begin
      last_filled_n = last_pending_r & ~hold_valid_r & ~des_wr_r;
    end
  end

  // State registers: synchronous reset wins over clk_en, otherwise advance only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_r         <= WORD_ZERO;
      cnt_r          <= CNT_ZERO;
      hold_r         <= WORD_ZERO;
      hold_valid_r   <= 1'b0;
      des_wr_r       <= 1'b0;
      des_out_r      <= WORD_ZERO;
      last_out_r     <= WORD_ZERO;
      last_size_r    <= CNT_ZERO;
      last_pending_r <= 1'b0;
      last_filled_r  <= 1'b0;
      overflow_r     <= 1'b0;
    end else if (clk_en) begin
      sreg_r         <= sreg_n;
      cnt_r          <= cnt_n;
      hold_r         <= hold_n;
      hold_valid_r   <= hold_valid_n;
      des_wr_r       <= des_wr_n;
      des_out_r      <= des_out_n;
      last_out_r     <= last_out_n;
      last_size_r    <= last_size_n;
      last_pending_r <= last_pending_n;
      last_filled_r  <= last_filled_n;
      overflow_r     <= overflow_n;
    end
  end

  assign bus.des_out     = des_out_r;
  assign bus.des_wr      = des_wr_r;
  assign bus.last_out    = last_out_r;
  assign bus.last_size   = last_size_r;
  assign bus.last_filled = last_filled_r;
  assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_pre_des_deser.sv
// Self-checking bench for pre_des_deser (default MSB-first build), scoreboard of DES words.
module tb_pre_des_deser;
  localparam int W  = 64;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;

  pre_des_deser_if #(.WORD_W(W), .CNT_W(CW)) bus ();

  pre_des_deser #(.WORD_W(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  bit div3 = 1'b0;
  int ph   = 0;

  // Each des_wr pulse spans exactly one negedge where the coming edge is enabled.
  always @(negedge clk) begin
    if (!rst && clk_en && bus.des_wr) obs_q.push_back(bus.des_out);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (div3) begin
      ph     = (ph == 2) ? 0 : ph + 1;
      clk_en = (ph == 0);
    end else begin
      clk_en = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_bit(input logic b, input logic last);
    logic was;
    bus.bit_in   = b;
    bus.bit_last = last;
    bus.bit_en   = 1'b1;
    do begin
      was = clk_en;
      step();
    end while (!was);
    bus.bit_en   = 1'b0;
    bus.bit_last = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] data, input int n, input logic last);
    for (int i = n - 1; i >= 0; i--) send_bit(data[i], last && (i == 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_filled(input int budget);
    int t = 0;
    while (bus.last_filled !== 1'b1 && t < budget) begin
      step();
      t++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.des_wr !== 1'b0) begin n_mis++; $display("FAIL rst_des_wr: got %0b want 0", bus.des_wr); end
    n_cmp++; if (bus.last_filled !== 1'b0) begin n_mis++; $display("FAIL rst_last_filled: got %0b want 0", bus.last_filled); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_mis++; $display("FAIL rst_overflow: got %0b want 0", bus.overflow); end
    n_cmp++; if (bus.last_size !== 6'd0) begin n_mis++; $display("FAIL rst_last_size: got %0d want 0", bus.last_size); end
    n_cmp++; if (bus.des_out !== 64'd0) begin n_mis++; $display("FAIL rst_des_out: got %h want 0", bus.des_out); end
    n_cmp++; if (bus.last_out !== 64'd0) begin n_mis++; $display("FAIL rst_last_out: got %h want 0", bus.last_out); end
  endtask

  task automatic test_word();
    logic [W-1:0] got, want;
    exp_q.push_back(64'h0123456789ABCDEF);
    send_word(64'h0123456789ABCDEF, W, 1'b0);
    n_cmp++; if (bus.des_wr !== 1'b0) begin n_mis++; $display("FAIL lat_early: got %0b want 0", bus.des_wr); end
    step();
    n_cmp++; if (bus.des_wr !== 1'b1) begin n_mis++; $display("FAIL lat_n1: got %0b want 1", bus.des_wr); end
    step();
    n_cmp++; if (bus.des_wr !== 1'b0) begin n_mis++; $display("FAIL pulse_width: got %0b want 0", bus.des_wr); end
    idle(3);
    n_cmp++; if (bus.overflow !== 1'b0) begin n_mis++; $display("FAIL word_overflow: got %0b want 0", bus.overflow); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_mis++; $display("FAIL word_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_mis++; $display("FAIL word_data: got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_busy();
    logic [W-1:0] got, want;
    bus.des_busy = 1'b1;
    exp_q.push_back({W{1'b1}});
    send_word({W{1'b1}}, W, 1'b0);
    idle(100);
    n_cmp++; if (obs_q.size() != 0) begin n_mis++; $display("FAIL busy_hold: got %0d writes want 0", obs_q.size()); end
    bus.des_busy = 1'b0;
    step();
    n_cmp++; if (bus.des_wr !== 1'b1) begin n_mis++; $display("FAIL busy_release: got %0b want 1", bus.des_wr); end
    idle(5);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_mis++; $display("FAIL busy_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_mis++; $display("FAIL busy_data: got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [W-1:0] got, want;
    bus.des_busy = 1'b1;
    exp_q.push_back(64'h0F1E2D3C4B5A6978);
    send_word(64'h0F1E2D3C4B5A6978, W, 1'b0);
    send_word(64'h123456789ABCDEF0, W, 1'b0);
    step();
    n_cmp++; if (bus.overflow !== 1'b1) begin n_mis++; $display("FAIL ovf_flag: got %0b want 1", bus.overflow); end
    bus.des_busy = 1'b0;
    idle(6);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_mis++; $display("FAIL ovf_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_mis++; $display("FAIL ovf_data: got %h want %h", got, want); end
    end
    do_reset();
  endtask

  task automatic run69(input string tag);
    logic [W-1:0] got, want;
    logic was;
    exp_q.push_back({32{2'b10}});
    send_word({32{2'b10}}, W, 1'b0);
    send_word(64'h16, 5, 1'b1);
    wait_filled(80);
    n_cmp++; if (bus.last_filled !== 1'b1) begin n_mis++; $display("FAIL %s_filled: got %0b want 1", tag, bus.last_filled); end
    n_cmp++; if (bus.last_size !== 6'd5) begin n_mis++; $display("FAIL %s_size: got %0d want 5", tag, bus.last_size); end
    n_cmp++; if (bus.last_out !== 64'hB000000000000000) begin n_mis++; $display("FAIL %s_last_out: got %h want b000000000000000", tag, bus.last_out); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_mis++; $display("FAIL %s_overflow: got %0b want 0", tag, bus.overflow); end
    bus.last_ack = 1'b1;
    do begin
      was = clk_en;
      step();
    end while (!was);
    bus.last_ack = 1'b0;
    n_cmp++; if (bus.last_filled !== 1'b0) begin n_mis++; $display("FAIL %s_ack: got %0b want 0", tag, bus.last_filled); end
    idle(6);
    n_cmp++; if (bus.last_filled !== 1'b0) begin n_mis++; $display("FAIL %s_ack_stay: got %0b want 0", tag, bus.last_filled); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_mis++; $display("FAIL %s_count: got %0d want %0d", tag, obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_mis++; $display("FAIL %s_data: got %h want %h", tag, got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_last69();
    run69("last69");
  endtask

  task automatic test_exact64();
    logic [W-1:0] got, want;
    exp_q.push_back(64'hC3A5_5A3C_0FF0_9966);
    send_word(64'hC3A5_5A3C_0FF0_9966, W, 1'b1);
    wait_filled(20);
    n_cmp++; if (bus.last_filled !== 1'b1) begin n_mis++; $display("FAIL ex64_filled: got %0b want 1", bus.last_filled); end
    n_cmp++; if (bus.last_size !== 6'd0) begin n_mis++; $display("FAIL ex64_size: got %0d want 0", bus.last_size); end
    n_cmp++; if (bus.last_out !== 64'd0) begin n_mis++; $display("FAIL ex64_last_out: got %h want 0", bus.last_out); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_mis++; $display("FAIL ex64_ovf_pre: got %0b want 0", bus.overflow); end
    send_word(64'h5, 3, 1'b0);
    idle(3);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_mis++; $display("FAIL ex64_blocked: got %0b want 1", bus.overflow); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_mis++; $display("FAIL ex64_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_mis++; $display("FAIL ex64_data: got %h want %h", got, want); end
    end
    bus.last_ack = 1'b1;
    step();
    bus.last_ack = 1'b0;
    do_reset();
  endtask

  task automatic test_clken_rst();
    logic [W-1:0] got, want;
    div3 = 1'b1;
    ph   = 0;
    do_reset();
    run69("en3");
    send_word(64'h2AAAAAAA, 30, 1'b0);
    do_reset();
    n_cmp++; if (bus.des_wr !== 1'b0) begin n_mis++; $display("FAIL mid_rst_des_wr: got %0b want 0", bus.des_wr); end
    n_cmp++; if (bus.last_filled !== 1'b0) begin n_mis++; $display("FAIL mid_rst_filled: got %0b want 0", bus.last_filled); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_mis++; $display("FAIL mid_rst_overflow: got %0b want 0", bus.overflow); end
    n_cmp++; if (bus.last_size !== 6'd0) begin n_mis++; $display("FAIL mid_rst_size: got %0d want 0", bus.last_size); end
    n_cmp++; if (bus.des_out !== 64'd0) begin n_mis++; $display("FAIL mid_rst_des_out: got %h want 0", bus.des_out); end
    n_cmp++; if (bus.last_out !== 64'd0) begin n_mis++; $display("FAIL mid_rst_last_out: got %h want 0", bus.last_out); end
    exp_q.push_back(64'hDEADBEEFCAFEF00D);
    send_word(64'hDEADBEEFCAFEF00D, W, 1'b0);
    idle(12);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_mis++; $display("FAIL fresh_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_mis++; $display("FAIL fresh_data: got %h want %h", got, want); end
    end
    div3 = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    clk_en       = 1'b1;
    bus.bit_in   = 1'b0;
    bus.bit_en   = 1'b0;
    bus.bit_last = 1'b0;
    bus.des_busy = 1'b0;
    bus.last_ack = 1'b0;
    test_reset();
    test_word();
    test_busy();
    test_overflow();
    test_last69();
    test_exact64();
    test_clken_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/pre_des_deser.md
Name: pre_des_deser

Overview:
- Serial-to-parallel front end that feeds the DES core.
- Collects a bit stream (bit_in/bit_en) into WORD_W-bit words, MSB first, and presents each full word to DES through a des_wr/des_busy handshake.
- Presents the trailing partial word of a message, left-aligned, through a last_filled/last_ack handshake.
- It is the receive-side counterpart of the post-DES serializer; the word and last-block formats match that serializer's input side.

Parameters:
- WORD_W, 64: word width. Must be a power of two, 8..64.
- CNT_W, $clog2(WORD_W): width of the bit counter and last_size.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- clk_en, input, 1: global clock enable. All state advances only when it is 1.
- bit_in, input, 1: serial data bit.
- bit_en, input, 1: bit_in is valid this cycle.
- bit_last, input, 1: qualified by bit_en. Marks the final bit of a message.
- des_busy, input, 1: DES cannot accept a word.
- des_out, output, WORD_W: full word to DES. Valid when des_wr=1.
- des_wr, output, 1: one-cycle write strobe to DES.
- last_out, output, WORD_W: trailing partial word, left-aligned, unused LSBs 0.
- last_size, output, CNT_W: number of valid bits in last_out (0..WORD_W-1).
- last_filled, output, 1: last_out/last_size are valid.
- last_ack, input, 1: consumer takes the last block. Qualified by clk_en.
- overflow, output, 1: sticky error flag.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of clk_en):
  - des_wr=0, last_filled=0, overflow=0, last_size=0.
  - Bit counter=0, hold_valid=0, last_pending=0.
  - des_out, last_out and the shift register: 0.
  - Reset mid-word or mid-handshake discards all data.
- clk_en=0: every register holds. Outputs are stable.
- Accept: clk_en&bit_en and the block is not blocked:
  - sreg <= {sreg[WORD_W-2:0], bit_in}; cnt <= cnt+1.
- Word completion: accepting a bit with cnt==WORD_W-1 does all of the following in the same cycle:
  - Full word {sreg[WORD_W-2:0],bit_in} goes to the hold register.
  - hold_valid <= 1; cnt <= 0.
- DES handshake: des_wr <= 1 for exactly one clk_en cycle when hold_valid & ~des_busy & ~des_wr.
  - des_out carries the hold data while des_wr=1.
  - hold_valid clears on the cycle des_wr is registered high.
  - Minimum latency: last bit accepted at edge N, des_wr high after edge N+1.
  - Back-to-back words are therefore spaced at least 2 clk_en cycles apart at the DES side. Words arrive every WORD_W bits, so this never limits throughput.
- Word completes while hold_valid=1 and no des_wr is issued that cycle:
  - New word is dropped; overflow <= 1; cnt <= 0.
- bit_last accepted:
  - If the bit completes a word: word goes to hold as above. last_pending is set with last_size=0 and last_out=0.
  - Otherwise: last_out <= partial bits left-aligned (first received bit at MSB), last_size <= cnt+1, cnt <= 0, last_pending <= 1.
- last_filled <= last_pending & ~hold_valid & ~des_wr. The last block is never offered before all preceding full words have been written to DES.
- last_ack with last_filled=1:
  - last_pending and last_filled clear next edge.
  - last_ack with last_filled=0 is ignored.
- Blocked: while last_pending=1, the block is blocked.
  - bits with bit_en are discarded; overflow <= 1.
  - A new message starts only after last_ack.
- Simultaneous events:
  - des_wr issue and a new word completion in the same cycle: the new word is stored, no overflow.
  - last_ack and bit_en in the same cycle: the bit is discarded (still blocked that edge).
- overflow clears only on rst.

Optional Feature:
- PRE_DES_LSB_FIRST_EN defined:
  - Bits shift in from the MSB side (sreg <= {bit_in, sreg[WORD_W-1:1]}), so the first bit received lands at bit 0 of a full word.
  - The partial last_out is right-aligned: the first bit received is at bit 0, valid bits occupy [last_size-1:0], and the upper bits are 0.
- Undefined: MSB-first, left-aligned, as above.

Test Plan:
- Reset, then stream 64 bits of 0x0123456789ABCDEF MSB-first with des_busy=0 -> one des_wr pulse, des_out=0x0123456789ABCDEF, overflow=0.
- Stream 0xFFFF...FF, des_busy=1 for 100 cycles, then release -> des_wr occurs 1 cycle after release with the correct word; no second pulse.
- 128 bits with des_busy held high throughout -> first word kept in hold, second word dropped, overflow=1. On release, exactly one des_wr with the first word.
- 69-bit message (64 bits 0xAAAA..AA, then 10110 with bit_last) -> des_wr with 0xAAAAAAAAAAAAAAAA, then last_filled=1, last_size=5, last_out=0xB000000000000000. last_ack -> last_filled=0 next edge.
- Exactly 64-bit message ending in bit_last -> des_wr with the word, then last_filled=1 with last_size=0. Bits sent before last_ack -> ignored, overflow=1.
- clk_en toggled 1-of-3 during the 69-bit case, plus rst asserted mid-word at bit 30 -> identical results per enabled cycle. After reset, all outputs are 0 and a fresh 64-bit word is assembled correctly.
